// File: rtl/pong_pkg.sv
// Shared definitions for the paddle bank: encoder step classification and
// the position-width helper used to size per-channel position registers.
package pong_pkg;

   // Decoded encoder movement for one cycle.
   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_DEC  = 2'd1,
      STEP_INC  = 2'd2,
      STEP_ERR  = 2'd3
   } step_t;

   // Bits needed to hold 0..field_w; at least 2 so a double step fits.
   function automatic int pos_width(input int field_w);
      int w;
      w = $clog2(field_w + 1);
      return (w < 2) ? 2 : w;
   endfunction

   // Classify (encoder - prev) mod 4: +1 moves toward bit 0, -1 away.
   function automatic step_t decode_step(input logic [1:0] diff);
      case (diff)
         2'd1:    return STEP_DEC;
         2'd3:    return STEP_INC;
         2'd2:    return STEP_ERR;
         default: return STEP_NONE;
      endcase
   endfunction

endpackage

// File: rtl/paddle_chan.sv
// One paddle channel: tracks the paddle LSB position from a 2-bit encoder,
// handles width changes, re-centring and saturation, and registers the
// bitmap. Optional two-cell acceleration is built when PADDLE_ACCEL_EN is
// defined.
module paddle_chan
   import pong_pkg::*;
#(
   parameter int FIELD_W   = 16,
   parameter int NARROW_W  = 4,
   parameter int WIDE_W    = 6,
   parameter int ACCEL_WIN = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [1:0]         encoder_value,
   input  logic               width_sel,
   input  logic               center,
   output logic [FIELD_W-1:0] paddle_o,
   output logic               moved,
   output logic               enc_err
);

   // Bad geometry stops elaboration.
   if (NARROW_W < 1 || NARROW_W > FIELD_W || WIDE_W < 1 || WIDE_W > FIELD_W ||
       ACCEL_WIN < 1) begin : g_bad_param
      $error("paddle_chan: invalid paddle width or acceleration window");
   end

   localparam int PW = pos_width(FIELD_W);
   localparam logic [PW-1:0] NARROW_MAX = PW'(FIELD_W - NARROW_W);
   localparam logic [PW-1:0] WIDE_MAX   = PW'(FIELD_W - WIDE_W);
   localparam logic [PW-1:0] NARROW_WP  = PW'(NARROW_W);
   localparam logic [PW-1:0] WIDE_WP    = PW'(WIDE_W);
   localparam logic [PW-1:0] RST_POS    = PW'((FIELD_W - WIDE_W) / 2);

   logic [PW-1:0]      pos;
   logic [1:0]         prev;
   logic               primed;

   logic [PW-1:0]      max_n;
   logic [PW-1:0]      w_n;
   logic [PW-1:0]      pos_c;
   logic [PW-1:0]      pos_n;
   logic [PW-1:0]      amt;
   logic               moved_n;
   logic [FIELD_W-1:0] bm_n;
   step_t              step;

   // Steps are only trusted once prev holds a real encoder sample.
   assign step = primed ? decode_step(encoder_value - prev) : STEP_NONE;

`ifdef PADDLE_ACCEL_EN
   localparam int CW_RAW = $clog2(ACCEL_WIN + 1);
   localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

   logic [CW-1:0] win_cnt;
   logic          last_inc;
   logic          streak_vld;
   logic          accel;

   // A same-direction step inside the window doubles the move.
   assign accel = streak_vld && (last_inc == (step == STEP_INC)) &&
                  (win_cnt < CW'(ACCEL_WIN));
   assign amt   = accel ? PW'(2) : PW'(1);

   // Streak tracking: cycles since the last step, saturating at the window.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win_cnt    <= '0;
         last_inc   <= 1'b0;
         streak_vld <= 1'b0;
      end else if (center || step == STEP_ERR) begin
         win_cnt    <= '0;
         streak_vld <= 1'b0;
      end else if (step == STEP_DEC || step == STEP_INC) begin
         win_cnt    <= '0;
         last_inc   <= (step == STEP_INC);
         streak_vld <= 1'b1;
      end else if (win_cnt != CW'(ACCEL_WIN)) begin
         win_cnt <= win_cnt + CW'(1);
      end
   end
`else
   assign amt = PW'(1);
`endif

   // Next position and bitmap: clamp to the new width, then centre or step.
   always_comb begin
      max_n   = width_sel ? WIDE_MAX : NARROW_MAX;
      w_n     = width_sel ? WIDE_WP : NARROW_WP;
      pos_c   = (pos > max_n) ? max_n : pos;
      pos_n   = pos_c;
      if (center) begin
         pos_n = max_n >> 1;
      end else if (step == STEP_DEC) begin
         pos_n = (pos_c >= amt) ? pos_c - amt : '0;
      end else if (step == STEP_INC) begin
         pos_n = ((max_n - pos_c) >= amt) ? pos_c + amt : max_n;
      end
      moved_n = (center || step == STEP_DEC || step == STEP_INC) &&
                (pos_n != pos_c);
      bm_n    = '0;
      for (int i = 0; i < FIELD_W; i++) begin
         bm_n[i] = (PW'(i) >= pos_n) && (PW'(i) < pos_n + w_n);
      end
   end

   // Channel state and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pos      <= RST_POS;
         prev     <= '0;
         primed   <= 1'b0;
         paddle_o <= '0;
         moved    <= 1'b0;
         enc_err  <= 1'b0;
      end else begin
         pos      <= pos_n;
         prev     <= encoder_value;
         primed   <= 1'b1;
         paddle_o <= bm_n;
         moved    <= moved_n;
         enc_err  <= (step == STEP_ERR);
      end
   end

endmodule

// File: rtl/paddle_bank.sv
// Bank of NUM_CH independent paddle channels sharing one clock and reset.
// Optional feature macro: PADDLE_ACCEL_EN (two-cell moves on fast streaks).
module paddle_bank
   import pong_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int FIELD_W   = 16,
   parameter int NARROW_W  = 4,
   parameter int WIDE_W    = 6,
   parameter int ACCEL_WIN = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [2*NUM_CH-1:0]       encoder_value,
   input  logic [NUM_CH-1:0]         width_sel,
   input  logic [NUM_CH-1:0]         center,
   output logic [FIELD_W*NUM_CH-1:0] paddle_o,
   output logic [NUM_CH-1:0]         moved,
   output logic [NUM_CH-1:0]         enc_err
);

   // One channel per slice of the packed buses.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      paddle_chan #(
         .FIELD_W  (FIELD_W),
         .NARROW_W (NARROW_W),
         .WIDE_W   (WIDE_W),
         .ACCEL_WIN(ACCEL_WIN)
      ) u_chan (
         .clk          (clk),
         .reset_n      (reset_n),
         .encoder_value(encoder_value[2*c +: 2]),
         .width_sel    (width_sel[c]),
         .center       (center[c]),
         .paddle_o     (paddle_o[FIELD_W*c +: FIELD_W]),
         .moved        (moved[c]),
         .enc_err      (enc_err[c])
      );
   end

endmodule

// File: doc/paddle_bank.md
PADDLE_BANK -- requirements
Module: paddle_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent paddle channels.
REQ-002 SHALL have parameter FIELD_W, default 16, cells per paddle bitmap.
REQ-003 SHALL have parameter NARROW_W, default 4, paddle width in cells when width_sel=0.
REQ-004 SHALL have parameter WIDE_W, default 6, paddle width in cells when width_sel=1.
REQ-005 SHALL have parameter ACCEL_WIN, default 8, the step-to-step cycle window for acceleration.
REQ-006 SHALL have port clk  input  1  the single clock, all state on the rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port encoder_value  input  2*NUM_CH  per-channel 2-bit signed encoder count, channel c at [2c+1:2c].
REQ-009 SHALL have port width_sel  input  NUM_CH  per-channel width select.
REQ-010 SHALL have port center  input  NUM_CH  per-channel synchronous re-centre request.
REQ-011 SHALL have port paddle_o  output  FIELD_W*NUM_CH  registered per-channel bitmap, channel c at [FIELD_W*(c+1)-1:FIELD_W*c].
REQ-012 SHALL have port moved  output  NUM_CH  one-cycle pulse when a channel's position changed.
REQ-013 SHALL have port enc_err  output  NUM_CH  one-cycle pulse on an encoder jump of 2.

Function
REQ-014 Per channel, SHALL keep pos = index of the paddle's LSB cell, range 0..FIELD_W-W, where W is the width currently selected.
REQ-015 Bitmap SHALL be W ones shifted left by pos; paddle_o SHALL be registered from next-state pos and width, with zero extra latency after the sampling edge.
REQ-016 diff SHALL be encoder_value minus prev, modulo 4; prev SHALL update every cycle.
REQ-017 diff=+1 SHALL decrement pos (toward bit 0); diff=-1 SHALL increment pos; diff=0 SHALL hold.
REQ-018 diff=2 SHALL hold pos and pulse enc_err for one cycle.
REQ-019 Moves SHALL saturate at pos=0 and pos=FIELD_W-W, with no wrap-around; a blocked step SHALL leave moved low.
REQ-020 A width change SHALL clamp pos to FIELD_W-W_new if it now exceeds that, otherwise hold pos; moved SHALL stay low.
REQ-021 center=1 SHALL set pos=(FIELD_W-W)/2 (integer division) and take priority over a simultaneous step.
REQ-022 moved SHALL pulse in the cycle paddle_o changes because of a step or center, and only when pos actually changes.
REQ-023 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.
REQ-024 Parameter checks: NARROW_W, WIDE_W <= FIELD_W and both >= 1; elaboration SHALL fail otherwise.

Reset
REQ-025 While reset_n=0: pos=(FIELD_W-WIDE_W)/2, prev=0, paddle_o=0, moved=0, enc_err=0, accel state cleared, primed=0.
REQ-026 The first edge after release SHALL load prev and paddle_o without moving, then set primed; steps SHALL be decoded only once primed=1.
REQ-027 Reset asserted mid-operation SHALL override everything immediately, asynchronously.

Configuration
REQ-028 With PADDLE_ACCEL_EN defined, a step in the same direction within ACCEL_WIN cycles of the previous accepted step SHALL move 2 cells, still saturating.
REQ-029 With PADDLE_ACCEL_EN defined, the per-channel window counter SHALL saturate; a reversal, center, or error SHALL reset the streak.
REQ-030 Without PADDLE_ACCEL_EN, every step SHALL move 1 cell and no window counter SHALL exist.

Structure
REQ-031 Shared package pong_pkg SHALL hold the step-direction enum (STEP_NONE, STEP_DEC, STEP_INC, STEP_ERR) and a clog2-based pos-width helper.
REQ-032 Per-channel logic SHALL live in sub-module paddle_chan, instantiated NUM_CH times by a generate loop.

Verification (defaults; ch0 unless noted)
REQ-033 Release reset with width_sel=1 and enc=0, then clock once -> paddle_o=0x07E0, moved=0.
REQ-034 width_sel=0, center=1 -> paddle_o=0x03C0, moved=1; then enc 0->1 -> paddle_o=0x01E0.
REQ-035 At pos=0, enc 1->2 (+1) -> paddle_o holds 0x000F, moved=0; enc 2->1 (-1) -> 0x001E.
REQ-036 At pos=12 (0xF000), switch width_sel to 1 -> pos=10, paddle_o=0xFC00, moved=0.
REQ-037 enc 0->2 -> enc_err=1 for one cycle, paddle_o unchanged; ch1 steps in the same cycle move ch1 only.
REQ-038 With PADDLE_ACCEL_EN, two -1 steps 3 cycles apart from 0x03C0 -> 0x0780, then 0x1E00; steps 20 cycles apart -> 1 cell each.
